// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input path: default sizes, the complex
// sample layout and the index bit-reversal helper.
package fft_pkg;

    localparam int LOG2N_DEFAULT  = 10;
    localparam int DATA_W_DEFAULT = 32;

    // Widest index the bit-reversal helper handles (N up to 65536).
    localparam int BITREV_MAX_W = 16;

    // Complex Q1.15 sample: real half in the upper bits, imaginary in the lower.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sample_t;

    // Reverse the low w bits of v: result[k] = v[w-1-k].
    // The caller zero-extends its index into v. After a full-width reversal,
    // the w meaningful bits sit at the top, so one right shift lands them at bit 0.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] v,
        input int unsigned             w
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int k = 0; k < BITREV_MAX_W; k++) begin
            r[k] = v[BITREV_MAX_W-1-k];
        end
        return r >> (BITREV_MAX_W - w);
    endfunction

endpackage

// File: rtl/fft_bitrev_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks (bank = MSB of
// the address). One write port and one registered read port with 1-cycle
// latency. The read register holds its value when no read is issued.
module fft_bitrev_bank_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port: store the incoming sample.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, updated only when a read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Streaming reorder stage: accepts N-point frames in natural order and
// emits them in bit-reversed index order. It uses two ping-pong banks so one
// frame can be written while the previous frame is read out.
//
// Handshake semantics (both AXI-Stream ports): a transfer happens on a rising
// edge where TVALID and TREADY are both high. Once TVALID is raised, it stays
// high with TDATA/TLAST stable until that transfer. TVALID never depends on
// TREADY of the same port.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] s_axis_TDATA,
    input  logic              s_axis_TVALID,
    output logic              s_axis_TREADY,
    input  logic              s_axis_TLAST,
    output logic [DATA_W-1:0] m_axis_TDATA,
    output logic              m_axis_TVALID,
    input  logic              m_axis_TREADY,
    output logic              m_axis_TLAST,
    output logic              frame_err
);

    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    // Write side state
    logic             wr_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [1:0]       full;

    // Read side state
    logic             rd_bank;
    logic [LOG2N-1:0] rd_cnt;
    logic             rd_pending;
    logic             rd_pending_last;

    // Output skid buffer; entry 0 is the head
    logic [1:0]        occ;
    logic [DATA_W-1:0] skid_data [2];
    logic [1:0]        skid_last;

    logic              frame_err_q;

    logic              wr_fire;
    logic              wr_at_last;
    logic              frame_done;
    logic              early_end;
    logic              missing_end;
    logic              rd_issue;
    logic              rd_at_last;
    logic [LOG2N-1:0]  rd_addr_rev;
    logic [DATA_W-1:0] ram_q;
    logic              out_valid;
    logic              out_fire;
    logic              push;
    logic              pop;

    assign s_axis_TREADY = !full[wr_bank] && !ap_rst;
    assign wr_fire       = s_axis_TVALID && s_axis_TREADY;
    assign wr_at_last    = (wr_cnt == CNT_LAST);
    assign frame_done    = wr_fire && wr_at_last;
    assign early_end     = wr_fire && s_axis_TLAST && !wr_at_last;
    assign missing_end   = frame_done && !s_axis_TLAST;

    // Read only when the skid buffer has room for everything already in
    // flight, so back-pressure can never drop a RAM result.
    assign rd_issue    = full[rd_bank] && ((occ + {1'b0, rd_pending}) < 2'd2);
    assign rd_at_last  = (rd_cnt == CNT_LAST);
    assign rd_addr_rev = LOG2N'(bitrev(BITREV_MAX_W'(rd_cnt), LOG2N));

    fft_bitrev_bank_ram #(
        .ADDR_W (LOG2N + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (ap_clk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data (s_axis_TDATA),
        .rd_en   (rd_issue),
        .rd_addr ({rd_bank, rd_addr_rev}),
        .rd_data (ram_q)
    );

    // Write pointer/counter: wrap on the Nth sample, discard a short frame.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (frame_done) begin
            wr_bank <= !wr_bank;
            wr_cnt  <= '0;
        end else if (early_end) begin
            wr_cnt  <= '0;
        end else if (wr_fire) begin
            wr_cnt  <= wr_cnt + LOG2N'(1);
        end
    end

    // Bank full flags: the set is written after the clear so the write side
    // wins if both ever hit the same bank.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            full <= '0;
        end else begin
            if (rd_issue && rd_at_last) begin
                full[rd_bank] <= 1'b0;
            end
            if (frame_done) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    // Read pointer/counter: release the bank once its last read is issued.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else if (rd_issue) begin
            if (rd_at_last) begin
                rd_bank <= !rd_bank;
                rd_cnt  <= '0;
            end else begin
                rd_cnt  <= rd_cnt + LOG2N'(1);
            end
        end
    end

    // Track the one read that can be in flight through the RAM register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
        end else begin
            rd_pending      <= rd_issue;
            rd_pending_last <= rd_issue && rd_at_last;
        end
    end

    // Output head: the skid buffer if it holds data, otherwise the RAM
    // register directly. Both are registers, so TREADY has no path to the
    // output.
    assign out_valid = (occ != 2'd0) || rd_pending;
    assign out_fire  = out_valid && m_axis_TREADY;
    assign pop       = out_fire && (occ != 2'd0);
    assign push      = rd_pending && !((occ == 2'd0) && m_axis_TREADY);

    // Skid buffer: shift on pop, then park a RAM result that was not consumed.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            occ       <= 2'd0;
            skid_last <= 2'b00;
        end else begin
            if (pop) begin
                skid_data[0] <= skid_data[1];
                skid_last[0] <= skid_last[1];
            end
            if (push) begin
                if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
                    skid_data[0] <= ram_q;
                    skid_last[0] <= rd_pending_last;
                end else begin
                    skid_data[1] <= ram_q;
                    skid_last[1] <= rd_pending_last;
                end
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_axis_TVALID = out_valid;
    assign m_axis_TDATA  = (occ != 2'd0) ? skid_data[0] : ram_q;
    assign m_axis_TLAST  = (occ != 2'd0) ? skid_last[0] : rd_pending_last;

    // Framing error pulse, one cycle after the offending handshake.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= early_end || missing_end;
        end
    end

    assign frame_err = frame_err_q;

    // Sanity: never finish and release the same bank in one cycle, and never
    // hold a full skid buffer with a read still in flight.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            assert (!(frame_done && rd_issue && rd_at_last && (wr_bank == rd_bank)));
            assert (!((occ == 2'd2) && rd_pending));
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    localparam int LOG2N  = 3;
    localparam int N      = 8;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              frame_err;

    fft_bitrev_reorder #(
        .LOG2N  (LOG2N),
        .DATA_W (DATA_W)
    ) dut (
        .ap_clk        (clk),
        .ap_rst        (rst),
        .s_axis_TDATA  (s_tdata),
        .s_axis_TVALID (s_tvalid),
        .s_axis_TREADY (s_tready),
        .s_axis_TLAST  (s_tlast),
        .m_axis_TDATA  (m_tdata),
        .m_axis_TVALID (m_tvalid),
        .m_axis_TREADY (m_tready),
        .m_axis_TLAST  (m_tlast),
        .frame_err     (frame_err)
    );

    // ---------------- scoreboard state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] exp_v;
    int br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int          ready_mode = 0;   // 0: high, 1: random, 2: driven by main
    int          err_cnt = 0;
    int          in_frames = 0;
    int          out_frames = 0;
    bit          chk_tready_en = 1'b0;
    bit          arm_first = 1'b0;
    int unsigned first_out_cyc = 0;
    int unsigned last_out_cyc = 0;
    int          out_cnt = 0;
    int unsigned hs_cyc = 0;
    int          stall_cnt = 0;

    function automatic logic [DATA_W-1:0] mk(input int v);
        logic [15:0] h;
        h = 16'(v);
        return {h, ~h};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // ---------------- monitor ----------------
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_last  = 1'b0;
    logic              prev_rst   = 1'b1;
    logic [DATA_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", 64'({m_tlast, m_tdata}), 64'({prev_last, prev_data}));
            end
            if (chk_tready_en && !s_tready)
                check("tready_low_only_both_full", 64'((in_frames - out_frames) >= 2), 64'd1);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got %0h expected nothing", {m_tlast, m_tdata});
                end else begin
                    exp_v = exp_q.pop_front();
                    check("out_data", 64'({m_tlast, m_tdata}), 64'(exp_v));
                end
                if (arm_first) begin
                    first_out_cyc = cyc;
                    arm_first = 1'b0;
                end
                last_out_cyc = cyc;
                out_cnt++;
                if (m_tlast) out_frames++;
            end
            if (frame_err) err_cnt++;
        end
        prev_valid = m_tvalid;
        prev_ready = m_tready;
        prev_last  = m_tlast;
        prev_data  = m_tdata;
        prev_rst   = rst;
    end

    // ---------------- output ready driver ----------------
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_tready = 1'b1;
            else if (ready_mode == 1) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input int v, input bit last, input bit frame_end);
        int guard;
        guard = 0;
        s_tdata  = mk(v);
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready) begin
            stall_cnt++;
            guard++;
            if (guard > 300) begin
                total_cnt++;
                $display("FAIL send_timeout: s_axis_TREADY stayed 0 for sample %0d", v);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
        end
        hs_cyc = cyc;
        if (frame_end) in_frames++;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit with_last);
        for (int i = 0; i < N; i++)
            exp_q.push_back({(i == N - 1) ? 1'b1 : 1'b0, mk(base + br8[i])});
        for (int i = 0; i < N; i++)
            send(base + i, with_last && (i == N - 1), i == N - 1);
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!m_tvalid && g < 50);
        check({name, "_valid_seen"}, 64'(m_tvalid), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int err0;
        int out0;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        @(negedge clk);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_tready", 64'(s_tready), 64'd1);
        check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;

        // Single frame: 0..7 -> 0,4,2,6,1,5,3,7, TVALID two cycles after last input
        err0 = err_cnt;
        send_frame(0, 1'b1);
        wait_valid("t1");
        check("t1_latency", 64'(cyc - hs_cyc), 64'd2);
        @(posedge clk);
        #1;
        wait_drain("t1");
        check("t1_no_err", 64'(err_cnt - err0), 64'd0);

        // Back-to-back: 4 frames, no input stall, 32 consecutive outputs
        stall_cnt = 0;
        out0 = out_cnt;
        arm_first = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(16'h100 + 16 * f, 1'b1);
        wait_drain("t2");
        check("t2_no_input_stall", 64'(stall_cnt), 64'd0);
        check("t2_out_count", 64'(out_cnt - out0), 64'd32);
        check("t2_consecutive", 64'(last_out_cyc - first_out_cyc), 64'd31);

        // Back-pressure: random output ready across 3 frames
        in_frames = 0;
        out_frames = 0;
        out0 = out_cnt;
        ready_mode = 1;
        chk_tready_en = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(16'h200 + 16 * f, 1'b1);
        wait_drain("t3");
        chk_tready_en = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        check("t3_out_count", 64'(out_cnt - out0), 64'd24);

        // Early end: 5 samples with TLAST on the 5th, then frame 10..17
        err0 = err_cnt;
        for (int i = 0; i < 4; i++) send(16'h300 + i, 1'b0, 1'b0);
        send(16'h304, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_err_pulse", 64'(frame_err), 64'd1);
        @(posedge clk);
        #1;
        send_frame(10, 1'b1);
        wait_drain("t4");
        check("t4_err_count", 64'(err_cnt - err0), 64'd1);

        // Missing end: frame 0..7 without TLAST is still output
        err0 = err_cnt;
        send_frame(0, 1'b0);
        @(negedge clk);
        check("t5_err_pulse", 64'(frame_err), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("t5");
        check("t5_err_count", 64'(err_cnt - err0), 64'd1);

        // Mid-frame reset with output index 3 pending
        ready_mode = 2;
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        send_frame(16'h500, 1'b1);
        wait_valid("t6");
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_tready = 1'b0;
        @(negedge clk);
        check("t6_popped_three", 64'(exp_q.size()), 64'd5);
        check("t6_pending_idx3", 64'({m_tlast, m_tdata}), 64'({1'b0, mk(16'h506)}));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_after_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6_after_rst_s_tready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        ready_mode = 0;
        send_frame(20, 1'b1);
        wait_drain("t6");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Streaming input reorder stage that sits directly upstream of the FFT core in the programmable logic, between the AXI DMA MM2S stream and the FFT data input. It accepts complex samples in natural order and emits each N-point frame in bit-reversed index order. The FFT core can then run its in-place decimation-in-time butterflies without an internal reorder pass. Ping-pong buffering lets frame k+1 be written while frame k is read out, giving sustained one-sample-per-cycle throughput.

## Interface
- LOG2N, default 10: log2 of the frame length N (N = 1024).
- DATA_W, default 32: sample width; [DATA_W-1:DATA_W/2] is real, [DATA_W/2-1:0] is imaginary, both signed Q1.15. The block treats samples as opaque.

Ports:
- ap_clk, in, 1: the single clock.
- ap_rst, in, 1: reset, synchronous and active-high.
- s_axis_TDATA, in, DATA_W: natural-order input sample.
- s_axis_TVALID, in, 1: input sample valid.
- s_axis_TREADY, out, 1: block can accept an input sample.
- s_axis_TLAST, in, 1: marks the last sample of a DMA frame.
- m_axis_TDATA, out, DATA_W: bit-reversed-order output sample.
- m_axis_TVALID, out, 1: output sample valid.
- m_axis_TREADY, in, 1: FFT core accepts the output sample.
- m_axis_TLAST, out, 1: high on output sample index N-1 of each frame.
- frame_err, out, 1: one-cycle pulse when the input framing is wrong.

## Operation
- Storage is two banks of N entries (bank 0 and bank 1), each with a full flag.
- **Write side**
  - Pointer wr_bank (1 bit) and counter wr_cnt (LOG2N bits).
  - On each input handshake, store TDATA at address {wr_bank, wr_cnt}, then increment wr_cnt.
  - On the handshake at wr_cnt = N-1:
    - set full[wr_bank];
    - toggle wr_bank;
    - clear wr_cnt.
  - s_axis_TREADY = !full[wr_bank] && !ap_rst.
- **Read side**
  - Pointer rd_bank (1 bit) and counter rd_cnt (LOG2N bits).
  - While full[rd_bank] is set, the block issues reads at address {rd_bank, bitrev(rd_cnt)}.
  - The output stage is a registered 2-entry skid buffer. A read is issued only when (skid occupancy + reads in flight) < 2, which guarantees no data loss under back-pressure.
  - After the read of rd_cnt = N-1 is issued:
    - clear full[rd_bank];
    - toggle rd_bank;
    - clear rd_cnt.
  - m_axis_TLAST travels with the data of rd_cnt = N-1.
- **Framing errors**
  - Early end: TLAST accepted with wr_cnt < N-1. The partial frame is discarded: wr_cnt clears, wr_bank and the full flags are unchanged, and frame_err pulses.
  - Missing end: sample N-1 accepted without TLAST. The frame is kept as normal and frame_err pulses.
  - After a missing end, write counting continues into the next frame. A TLAST that arrives later is judged against the new count.
- **Simultaneous events**
  - If full[x] is set by the write side and cleared by the read side in the same cycle, they act on different banks by construction.
  - If the write side finishes bank x in the same cycle the read side releases bank x (only possible when x is empty on the write side), the write side wins. This cannot occur legally; assert on it in simulation.
- **Bit reversal**: bitrev(i)[k] = i[LOG2N-1-k]. For N = 8 the output order is 0, 4, 2, 6, 1, 5, 3, 7.

## Timing
- **Reset values**, held during ap_rst and equal to these values in the cycle it deasserts:
  - s_axis_TREADY = 0 while ap_rst is high, then 1 in the first cycle after release;
  - m_axis_TVALID = 0, m_axis_TLAST = 0, frame_err = 0;
  - m_axis_TDATA is don't-care;
  - all counters, pointers and full flags are 0;
  - the skid buffer is empty.
- A reset in mid-frame discards all buffered and partial data, with no output glitch.
- RAM read latency is 1 cycle.
- Latency: if the last input handshake is at cycle t, full is set at t+1, the first read is issued at t+1, and m_axis_TVALID rises at t+2.
- Throughput: with m_axis_TREADY held high, the N outputs of a frame appear on N consecutive cycles, and input TREADY stays high continuously across frames.
- AXI-Stream rules:
  - m_axis_TVALID, once high, never drops until the handshake completes;
  - TDATA and TLAST are stable while TVALID is high and TREADY is low;
  - there is no combinational path from m_axis_TREADY to m_axis_TVALID or m_axis_TDATA.
- frame_err is registered and pulses in the cycle after the offending handshake.

## Structure
- Shared package fft_pkg holds:
  - LOG2N_DEFAULT and DATA_W_DEFAULT;
  - the sample typedef (signed re/im halves);
  - the bitrev function, parameterised by width.
- Sub-module fft_bitrev_bank_ram: simple dual-port RAM, 2N × DATA_W, one write port, one registered read port with 1-cycle latency, inferable as block RAM.
- The top level contains the write and read counters, the full flags, the skid buffer and the error logic. Expected size is about 200 lines.

## Test plan
All scenarios use LOG2N = 3 (N = 8).
- Single frame: input 0..7 with TLAST on 7 and TREADY held high -> output 0, 4, 2, 6, 1, 5, 3, 7; TLAST only on 7; first TVALID 2 cycles after the last input handshake.
- Back-to-back stream: 4 frames streamed continuously -> s_axis_TREADY never drops after the first cycle; 32 outputs on consecutive cycles, each frame bit-reversed.
- Back-pressure: m_axis_TREADY random at 50% while 3 frames are input -> no loss or duplication; TVALID and TDATA stable while stalled; s_axis_TREADY drops only when both banks are full.
- Early end: TLAST on the 5th sample, then a correct frame 10..17 -> one frame_err pulse; output is only 10, 14, 12, 16, 11, 15, 13, 17.
- Missing end: frame 0..7 without TLAST -> frame_err pulses and the frame is still output bit-reversed.
- Mid-frame reset: ap_rst asserted for 1 cycle while output index 3 is pending -> TVALID is 0 the next cycle, TREADY is 1 the cycle after, and a fresh frame then reorders correctly.
